mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter: OP_W, default 8, operand width; only 8 is supported; product width is 2*OP_W.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid in 1, req0_ready out 1, req0_a in OP_W, req0_b in OP_W -- requester 0 operand handshake.
REQ-005 SHALL have ports: req1_valid in 1, req1_ready out 1, req1_a in OP_W, req1_b in OP_W -- requester 1 operand handshake.
REQ-006 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_id out 1 (winning requester), rsp_p out 2*OP_W (product).

Function
REQ-007 SHALL share one multiplier instance between the two requesters; at most one transaction in flight.
REQ-008 SHALL implement FSM states IDLE, CALC, (CALC2 when macro defined), HOLD.
REQ-009 IDLE: if no reqN_valid is high, stay in IDLE; otherwise grant one requester, capture its a/b into operand registers, record id, go to CALC.
REQ-010 Arbitration: round-robin; a single valid requester always wins; when both are valid, the requester not granted last wins; the pointer updates only on grant.
REQ-011 reqN_ready SHALL be high only in IDLE, only for the granted requester, for exactly that cycle (combinational grant); the handshake is reqN_valid & reqN_ready.
REQ-012 CALC (macro undefined): register the multiplier output into rsp_p, set rsp_valid, go to HOLD.
REQ-013 HOLD: hold rsp_valid, rsp_id and rsp_p stable while rsp_ready is low; on rsp_valid & rsp_ready, clear rsp_valid next cycle and return to IDLE.
REQ-014 Latency: handshake in cycle T -> rsp_valid high in cycle T+2 (T+3 with macro); peak throughput one product per 3 cycles with rsp_ready tied high.
REQ-015 Product SHALL be the unsigned full-width 2*OP_W result; no truncation or overflow (255*255 = 0xFE01).
REQ-016 A requester dropping valid before it is granted SHALL have no effect; valid held after an accept is a new transaction.
REQ-017 Operand-input changes after accept SHALL NOT affect the in-flight product.

Reset
REQ-018 rst high at a clock edge SHALL force state IDLE, rsp_valid=0, rsp_id=0, rsp_p=0, operand registers 0, and the pointer favouring requester 0.
REQ-019 Reset mid-operation (CALC/CALC2/HOLD) SHALL drop the in-flight transaction with no response; reqN_ready=0 while rst is high.

Configuration
REQ-020 Macro MULT_OUT_PIPE_EN defined: adds state CALC2 and a register after the multiplier output; CALC->CALC2->HOLD; latency T+3.
REQ-021 MULT_OUT_PIPE_EN undefined: no CALC2, CALC->HOLD; latency T+2; arbitration and handshake are otherwise identical.

Structure
REQ-022 Package mult_pkg SHALL hold OP_W, the PROD_W=2*OP_W constant, the FSM state enum, and the requester-id typedef.
REQ-023 SHALL instantiate the existing 8-bit Wallace tree multiplier as the single sub-module (wallace_mult8); no other arithmetic is permitted in the block.

Verification
REQ-024 req0 a=0xFF b=0xFF, rsp_ready=1 -> rsp_valid at T+2, rsp_p=0xFE01, rsp_id=0.
REQ-025 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; products are correct per id.
REQ-026 req1 a=0x0C b=0x0D, rsp_ready low 5 cycles -> rsp_p=0x009C held stable, both ready low, accept only after release.
REQ-027 rst pulsed in CALC -> next cycle rsp_valid=0, state IDLE; no response is emitted for the dropped transaction.
REQ-028 a=0x00 b=0x5A -> rsp_p=0x0000; with MULT_OUT_PIPE_EN defined, the same stimulus gives rsp_valid at T+3.
REQ-029 random a/b on both ports, random rsp_ready -> every response matches a*b of the accepted operands with the correct id, in grant order.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shared-multiplier arbiter and its Wallace tree multiplier.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
  } csa_t;

endpackage

// File: rtl/wallace_mult8.sv
// 8x8 unsigned Wallace tree multiplier: partial products reduced by 3:2 carry-save
// layers down to two rows, then one carry-propagate adder.
module wallace_mult8
  import mult_pkg::*;
(
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic [PROD_W-1:0] p
);

  function automatic csa_t csa(input logic [PROD_W-1:0] x,
                               input logic [PROD_W-1:0] y,
                               input logic [PROD_W-1:0] z);
    csa_t r;
    r.sum   = x ^ y ^ z;
    r.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  logic [PROD_W-1:0] pp [8];
  csa_t l1_a, l1_b, l2_a, l2_b, l3_a, l4_a;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = PROD_W'(a & {8{b[i]}}) << i;
    end
  end

  // Carry beyond bit 15 is always zero because the full product fits in PROD_W bits.
  always_comb begin
    l1_a = csa(pp[0], pp[1], pp[2]);
    l1_b = csa(pp[3], pp[4], pp[5]);
    l2_a = csa(l1_a.sum, l1_a.carry, l1_b.sum);
    l2_b = csa(l1_b.carry, pp[6], pp[7]);
    l3_a = csa(l2_a.sum, l2_a.carry, l2_b.sum);
    l4_a = csa(l3_a.sum, l3_a.carry, l2_b.carry);
    p    = l4_a.sum + l4_a.carry;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Two requesters share one wallace_mult8 via a round-robin arbiter, one transaction in flight.
// Define MULT_OUT_PIPE_EN to add a register after the multiplier (extra CALC2 state, latency T+3).
module mult_share_arbiter #(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [2*OP_W-1:0] rsp_p
);
  import mult_pkg::*;

  state_e            state_q, state_d;
  req_id_t           ptr_q, ptr_d;
  req_id_t           rsp_id_q, rsp_id_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2*OP_W-1:0] rsp_p_q, rsp_p_d;
  logic [PROD_W-1:0] prod;
  logic              grant_vld;
  req_id_t           grant_id;
`ifdef MULT_OUT_PIPE_EN
  logic [PROD_W-1:0] prod_pipe_q, prod_pipe_d;
`endif

  wallace_mult8 u_mult (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  // ptr_q names the requester that wins a tie; a lone valid requester always wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ptr_q;
    else                          grant_id = req1_valid;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
`ifdef MULT_OUT_PIPE_EN
    prod_pipe_d = prod_pipe_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req0_ready = !rst && (grant_id == 1'b0);
          req1_ready = !rst && (grant_id == 1'b1);
          op_a_d     = grant_id ? req1_a : req0_a;
          op_b_d     = grant_id ? req1_b : req0_b;
          rsp_id_d   = grant_id;
          ptr_d      = !grant_id;
          state_d    = CALC;
        end
      end
      CALC: begin
`ifdef MULT_OUT_PIPE_EN
        prod_pipe_d = prod;
        state_d     = CALC2;
`else
        rsp_p_d     = prod;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
`endif
      end
`ifdef MULT_OUT_PIPE_EN
      CALC2: begin
        rsp_p_d     = prod_pipe_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
`endif
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      rsp_id_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
`ifdef MULT_OUT_PIPE_EN
      prod_pipe_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
`ifdef MULT_OUT_PIPE_EN
      prod_pipe_q <= prod_pipe_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized scenarios for mult_share_arbiter with hand-computed expectations.
module tb_mult_share_arbiter;

`ifdef MULT_OUT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.OP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_a = 8'h12; req0_b = 8'h34; req1_a = 8'h56; req1_b = 8'h78;
    cyc(); cyc(); #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%b exp=0", rsp_id); end
    total++; if (rsp_p !== 16'h0000) begin bad++; $display("FAIL reset_p got=%h exp=0000", rsp_p); end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_max();
    int n;
    cyc();
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; rsp_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL max_ready0 got=%b exp=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL max_ready1 got=%b exp=0", req1_ready); end
    n = 0;
    do begin cyc(); req0_valid = 1'b0; n++; end while (!rsp_valid && n < 10);
    total++; if (n !== LAT) begin bad++; $display("FAIL max_latency got=%0d exp=%0d", n, LAT); end
    total++; if (rsp_p !== 16'hFE01) begin bad++; $display("FAIL max_product got=%h exp=fe01", rsp_p); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL max_id got=%b exp=0", rsp_id); end
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL max_valid_clear got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_alternate();
    int n;
    logic exp_id;
    logic [15:0] exp_p;
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h03;
    rsp_ready = 1'b1;
    #1;
    exp_id = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 10) begin cyc(); n++; end
      total++; if (req1_ready !== exp_id || req0_ready !== !exp_id) begin
        bad++; $display("FAIL alt_grant%0d got=%b%b exp_id=%b", k, req1_ready, req0_ready, exp_id);
      end
      exp_p = exp_id ? 16'h0180 : 16'h0242;
      n = 0;
      do begin cyc(); n++; end while (!rsp_valid && n < 10);
      total++; if (rsp_id !== exp_id) begin bad++; $display("FAIL alt_id%0d got=%b exp=%b", k, rsp_id, exp_id); end
      total++; if (rsp_p !== exp_p) begin bad++; $display("FAIL alt_p%0d got=%h exp=%h", k, rsp_p, exp_p); end
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      exp_id = !exp_id;
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int n;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 8'h0C; req1_b = 8'h0D; rsp_ready = 1'b0;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_grant got=%b exp=1", req1_ready); end
    cyc();
    req1_valid = 1'b0; req1_a = 8'hFF; req1_b = 8'hFF;
    n = 1;
    while (!rsp_valid && n < 10) begin cyc(); n++; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_p !== 16'h009C || rsp_id !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d got=v%b p=%h id=%b exp=v1 p=009c id=1", i, rsp_valid, rsp_p, rsp_id);
      end
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready%0d got=%b%b exp=00", i, req1_ready, req0_ready);
      end
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_before_release got=%b exp=1", rsp_valid); end
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_release got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h09; rsp_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rm_grant got=%b exp=1", req0_ready); end
    cyc();
    req0_valid = 1'b0; rst = 1'b1;
    cyc();
    req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", rsp_valid); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rm_ready_in_rst got=%b exp=0", req1_ready); end
    cyc();
    rst = 1'b0;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rm_idle_grant got=%b exp=1", req1_ready); end
    n = 0;
    do begin cyc(); req1_valid = 1'b0; n++; end while (!rsp_valid && n < 10);
    total++; if (n !== LAT || rsp_p !== 16'h000C || rsp_id !== 1'b1) begin
      bad++; $display("FAIL rm_next_rsp got=n%0d p=%h id=%b exp=n%0d p=000c id=1", n, rsp_p, rsp_id, LAT);
    end
    cyc();
  endtask

  task automatic test_zero();
    int n;
    req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h5A; rsp_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL zero_grant got=%b exp=1", req0_ready); end
    n = 0;
    do begin cyc(); req0_valid = 1'b0; n++; end while (!rsp_valid && n < 10);
    total++; if (n !== LAT) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", n, LAT); end
    total++; if (rsp_p !== 16'h0000 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL zero_product got=p%h id%b exp=p0000 id0", rsp_p, rsp_id);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [16:0] exp_q[$];
    logic [16:0] head;
    for (int c = 0; c < 420; c++) begin
      cyc();
      if (c < 400) begin
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom);
        rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      end
      #1;
      total++; if (req0_ready & req1_ready) begin bad++; $display("FAIL rnd_both_ready cycle=%0d got=11 exp=not both", c); end
      if (req0_valid & req0_ready) exp_q.push_back({1'b0, 16'(req0_a) * 16'(req0_b)});
      if (req1_valid & req1_ready) exp_q.push_back({1'b1, 16'(req1_a) * 16'(req1_b)});
      if (rsp_valid & rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected got=id%b p=%h exp=none", rsp_id, rsp_p);
        end else begin
          head = exp_q.pop_front();
          if ({rsp_id, rsp_p} !== head) begin
            bad++; $display("FAIL rnd_rsp got=id%b p=%h exp=id%b p=%h", rsp_id, rsp_p, head[16], head[15:0]);
          end
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d pending exp=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_max();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
